// File: rtl/fnanunbox_pkg.sv
// Shared FP definitions: format codes, per-format field widths, fclass bit
// indices and the unpacked-operand record used by the unbox and fclass paths.
package fnanunbox_pkg;

  localparam logic [1:0] S_FMT = 2'b00;
  localparam logic [1:0] D_FMT = 2'b01;
  localparam logic [1:0] H_FMT = 2'b10;
  localparam logic [1:0] Q_FMT = 2'b11;

  localparam int unsigned S_LEN = 32;
  localparam int unsigned S_NE  = 8;
  localparam int unsigned S_NF  = 23;
  localparam int unsigned D_LEN = 64;
  localparam int unsigned D_NE  = 11;
  localparam int unsigned D_NF  = 52;
  localparam int unsigned H_LEN = 16;
  localparam int unsigned H_NE  = 5;
  localparam int unsigned H_NF  = 10;
  localparam int unsigned Q_LEN = 128;
  localparam int unsigned Q_NE  = 15;
  localparam int unsigned Q_NF  = 112;

  localparam int unsigned CLS_NINF  = 0;
  localparam int unsigned CLS_NNORM = 1;
  localparam int unsigned CLS_NSUB  = 2;
  localparam int unsigned CLS_NZERO = 3;
  localparam int unsigned CLS_PZERO = 4;
  localparam int unsigned CLS_PSUB  = 5;
  localparam int unsigned CLS_PNORM = 6;
  localparam int unsigned CLS_PINF  = 7;
  localparam int unsigned CLS_SNAN  = 8;
  localparam int unsigned CLS_QNAN  = 9;

  // Sized for the widest format; narrower builds use the low exp / high frac bits.
  typedef struct packed {
    logic           sgn;
    logic [Q_NE-1:0] exp;
    logic [Q_NF-1:0] frac;
    logic [9:0]     cls;
    logic           unboxed;
    logic           illegal;
  } unpacked_t;

  function automatic int unsigned fmt_len(input logic [1:0] fmt);
    case (fmt)
      S_FMT:   return S_LEN;
      D_FMT:   return D_LEN;
      H_FMT:   return H_LEN;
      default: return Q_LEN;
    endcase
  endfunction

  function automatic logic [Q_NE-1:0] exp_ones(input logic [1:0] fmt);
    case (fmt)
      S_FMT:   return 15'h00ff;
      D_FMT:   return 15'h07ff;
      H_FMT:   return 15'h001f;
      default: return 15'h7fff;
    endcase
  endfunction

endpackage

// File: rtl/fnanunbox_fclassify.sv
// Combinational fclass: unpacked sign/exponent/left-aligned fraction to the
// 10-bit one-hot class mask. Shared with the fclass instruction path.
module fclassify
  import fnanunbox_pkg::*;
#(
  parameter int unsigned NE = 11,
  parameter int unsigned NF = 52
) (
  input  logic [1:0]    fmt,
  input  logic          sgn,
  input  logic [NE-1:0] exp,
  input  logic [NF-1:0] frac,
  output logic [9:0]    cls
);

  logic exp_max;
  logic exp_zero;
  logic frac_zero;

  assign exp_max   = (exp == NE'(exp_ones(fmt)));
  assign exp_zero  = (exp == '0);
  assign frac_zero = (frac == '0);

  always_comb begin
    cls = '0;
    if (exp_max) begin
      if (frac_zero)          cls[sgn ? CLS_NINF : CLS_PINF] = 1'b1;
      else if (frac[NF-1])    cls[CLS_QNAN] = 1'b1;
      else                    cls[CLS_SNAN] = 1'b1;
    end else if (exp_zero) begin
      if (frac_zero)          cls[sgn ? CLS_NZERO : CLS_PZERO] = 1'b1;
      else                    cls[sgn ? CLS_NSUB : CLS_PSUB] = 1'b1;
    end else begin
      cls[sgn ? CLS_NNORM : CLS_PNORM] = 1'b1;
    end
  end

endmodule

// File: rtl/fnanunbox.sv
// NaN-box check, canonical-NaN substitution, unpack and fclass in a two-stage
// valid/ready pipeline. Half precision is enabled by defining ZFH_SUPPORT_EN.
module fnanunbox
  import fnanunbox_pkg::*;
#(
  parameter int unsigned FLEN = 64,
  parameter int unsigned NE   = (FLEN == 128) ? 15 : (FLEN == 64) ? 11 : 8,
  parameter int unsigned NF   = (FLEN == 128) ? 112 : (FLEN == 64) ? 52 : 23
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            Flush,
  input  logic            InValid,
  output logic            InReady,
  input  logic [FLEN-1:0] X,
  input  logic [1:0]      Fmt,
  output logic            OutValid,
  input  logic            OutReady,
  output logic [1:0]      OutFmt,
  output logic            OutSgn,
  output logic [NE-1:0]   OutExp,
  output logic [NF-1:0]   OutFrac,
  output logic [9:0]      OutClass,
  output logic            OutUnboxed,
  output logic            OutIllegalFmt
);

  function automatic logic fmt_legal(input logic [1:0] f);
    case (f)
      S_FMT:   return 1'b1;
      D_FMT:   return FLEN >= 64;
`ifdef ZFH_SUPPORT_EN
      H_FMT:   return 1'b1;
`else
      H_FMT:   return 1'b0;
`endif
      default: return FLEN == 128;
    endcase
  endfunction

  logic            s1_valid;
  logic [FLEN-1:0] x_q;
  logic [1:0]      fmt_q;
  logic            boxed_q;
  logic            illegal_q;
  logic [FLEN-1:0] lowmask;
  logic            boxed_d;
  logic            s1_ready;
  logic            s2_ready;

  assign s2_ready = !OutValid || OutReady;
  assign s1_ready = !s1_valid || s2_ready;
  assign InReady  = s1_ready;

  // Bits inside the format are forced to 1 so only the box bits decide.
  always_comb begin
    lowmask = '0;
    for (int i = 0; i < FLEN; i++) lowmask[i] = (i < int'(fmt_len(Fmt)));
  end
  assign boxed_d = &(X | lowmask);

  logic          d_sgn, q_sgn, h_sgn;
  logic [NE-1:0] d_exp, q_exp, h_exp;
  logic [NF-1:0] d_frac, q_frac, h_frac;

  if (FLEN >= 64) begin : g_dfmt
    assign d_sgn  = x_q[63];
    assign d_exp  = NE'(x_q[62:52]);
    assign d_frac = NF'(x_q[51:0]) << (NF - D_NF);
  end else begin : g_nodfmt
    assign d_sgn  = 1'b0;
    assign d_exp  = '0;
    assign d_frac = '0;
  end

  if (FLEN == 128) begin : g_qfmt
    assign q_sgn  = x_q[127];
    assign q_exp  = NE'(x_q[126:112]);
    assign q_frac = NF'(x_q[111:0]);
  end else begin : g_noqfmt
    assign q_sgn  = 1'b0;
    assign q_exp  = '0;
    assign q_frac = '0;
  end

`ifdef ZFH_SUPPORT_EN
  assign h_sgn  = x_q[15];
  assign h_exp  = NE'(x_q[14:10]);
  assign h_frac = NF'(x_q[9:0]) << (NF - H_NF);
`else
  assign h_sgn  = 1'b0;
  assign h_exp  = '0;
  assign h_frac = '0;
`endif

  logic [1:0]    efmt;
  logic          sgn_n;
  logic [NE-1:0] exp_n;
  logic [NF-1:0] frac_n;
  logic [9:0]    cls_n;

  always_comb begin
    efmt   = illegal_q ? S_FMT : fmt_q;
    sgn_n  = x_q[31];
    exp_n  = NE'(x_q[30:23]);
    frac_n = NF'(x_q[22:0]) << (NF - S_NF);
    case (efmt)
      D_FMT:   begin sgn_n = d_sgn; exp_n = d_exp; frac_n = d_frac; end
      H_FMT:   begin sgn_n = h_sgn; exp_n = h_exp; frac_n = h_frac; end
      Q_FMT:   begin sgn_n = q_sgn; exp_n = q_exp; frac_n = q_frac; end
      default: ;
    endcase
    if (illegal_q || !boxed_q) begin
      sgn_n  = 1'b0;
      exp_n  = NE'(exp_ones(efmt));
      frac_n = {1'b1, {(NF-1){1'b0}}};
    end
  end

  fclassify #(
    .NE(NE),
    .NF(NF)
  ) u_fclassify (
    .fmt (efmt),
    .sgn (sgn_n),
    .exp (exp_n),
    .frac(frac_n),
    .cls (cls_n)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid      <= 1'b0;
      x_q           <= '0;
      fmt_q         <= '0;
      boxed_q       <= 1'b0;
      illegal_q     <= 1'b0;
      OutValid      <= 1'b0;
      OutFmt        <= '0;
      OutSgn        <= 1'b0;
      OutExp        <= '0;
      OutFrac       <= '0;
      OutClass      <= '0;
      OutUnboxed    <= 1'b0;
      OutIllegalFmt <= 1'b0;
    end else if (Flush) begin
      s1_valid <= 1'b0;
      OutValid <= 1'b0;
    end else begin
      if (s1_ready) begin
        s1_valid <= InValid;
        if (InValid) begin
          x_q       <= X;
          fmt_q     <= Fmt;
          boxed_q   <= boxed_d;
          illegal_q <= !fmt_legal(Fmt);
        end
      end
      if (s2_ready) begin
        OutValid <= s1_valid;
        if (s1_valid) begin
          OutFmt        <= fmt_q;
          OutSgn        <= sgn_n;
          OutExp        <= exp_n;
          OutFrac       <= frac_n;
          OutClass      <= cls_n;
          OutUnboxed    <= !illegal_q && !boxed_q;
          OutIllegalFmt <= illegal_q;
        end
      end
    end
  end

endmodule
